// File: rtl/mem_responder.sv
// Single-port 16-bit word memory that answers Rd/Wr requests a fixed LATENCY cycles after acceptance.
// Accepts in IDLE or RESP, stalls in WAIT, and flags illegal requests with a one-cycle Err.
module mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err,
    output logic [15:0] ReqCount
);

    // state | meaning
    // IDLE  | nothing in flight, accepting
    // WAIT  | request latched, counting down, stalling
    // RESP  | Done cycle, storage already updated, accepting
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_wr_q, op_wr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   dout_q, dout_d;
    logic          err_q, err_d;
    logic [15:0]   req_cnt_q, req_cnt_d;

    logic [15:0]   mem [0:(1<<AW)-1];

    logic          req_legal, req_illegal;
    logic          enter_resp, resp_wr;
    logic [AW-1:0] resp_idx;
    logic [15:0]   resp_wdata;
    logic          addr_unused;

    assign req_legal   = (Rd ^ Wr) & ~Addr[0];
    assign req_illegal = (Rd | Wr) & ~req_legal;
    assign addr_unused = ^(Addr >> (AW + 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        req_cnt_d  = req_cnt_q;
        enter_resp = 1'b0;
        resp_wr    = op_wr_q;
        resp_idx   = idx_q;
        resp_wdata = wdata_q;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (req_legal) begin
                    op_wr_d = Wr;
                    idx_d   = Addr[AW:1];
                    wdata_d = DataIn;
                    cnt_d   = LAT_M1;
                    if (req_cnt_q != 16'hFFFF) begin
                        req_cnt_d = req_cnt_q + 16'd1;
                    end
                    // With LATENCY 1 the RESP edge is the acceptance edge, so bypass the latch.
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        resp_wr    = Wr;
                        resp_idx   = Addr[AW:1];
                        resp_wdata = DataIn;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (req_illegal) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout_d = (enter_resp && !resp_wr) ? mem[resp_idx] : dout_q;

    // Storage is deliberately left out of the reset branch: contents survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op_wr_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 16'h0000;
            dout_q    <= 16'h0000;
            err_q     <= 1'b0;
            req_cnt_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            req_cnt_q <= req_cnt_d;
            if (enter_resp && resp_wr) begin
                mem[resp_idx] <= resp_wdata;
            end
        end
    end

    assign DataOut  = dout_q;
    assign Done     = (state_q == RESP);
    assign Stall    = (state_q == WAIT);
    assign Err      = err_q;
    assign ReqCount = req_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=1 instance driven from a vector table and a
// LATENCY=4 instance driven by hand-written multi-cycle sequences.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rd1, wr1, done1, stall1, err1;
    logic [15:0] addr1, din1, dout1, cnt1;
    logic        rst4, rd4, wr4, done4, stall4, err4;
    logic [15:0] addr4, din4, dout4, cnt4;

    int checks = 0;
    int errors = 0;

    mem_responder #(.LATENCY(1), .AW(8)) dut1 (
        .clk(clk), .rst(rst1), .Rd(rd1), .Wr(wr1), .Addr(addr1), .DataIn(din1),
        .DataOut(dout1), .Done(done1), .Stall(stall1), .Err(err1), .ReqCount(cnt1)
    );

    mem_responder #(.LATENCY(4), .AW(8)) dut4 (
        .clk(clk), .rst(rst4), .Rd(rd4), .Wr(wr4), .Addr(addr4), .DataIn(din4),
        .DataOut(dout4), .Done(done4), .Stall(stall4), .Err(err4), .ReqCount(cnt4)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        done;
        logic        err;
        logic [15:0] dout;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] din, input logic done, input logic err,
                                input logic [15:0] dout, input logic [15:0] cnt);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
        v.done = done; v.err = err; v.dout = dout; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // rd, wr, addr, din -> done, err, dout, count (observed one edge later)
        vecs[0]  = mk(0, 1, 16'h0002, 16'h1234, 1, 0, 16'h0000, 16'd1);
        vecs[1]  = mk(1, 0, 16'h0002, 16'h0000, 1, 0, 16'h1234, 16'd2);
        vecs[2]  = mk(0, 1, 16'h0002, 16'h5678, 1, 0, 16'h1234, 16'd3);
        vecs[3]  = mk(1, 0, 16'h0002, 16'h0000, 1, 0, 16'h5678, 16'd4);
        vecs[4]  = mk(0, 1, 16'h0004, 16'hCAFE, 1, 0, 16'h5678, 16'd5);
        vecs[5]  = mk(1, 1, 16'h0004, 16'h0000, 0, 1, 16'h5678, 16'd5);
        vecs[6]  = mk(1, 0, 16'h0005, 16'h0000, 0, 1, 16'h5678, 16'd5);
        vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h5678, 16'd5);
        vecs[8]  = mk(1, 0, 16'h0004, 16'h0000, 1, 0, 16'hCAFE, 16'd6);
        vecs[9]  = mk(0, 1, 16'h0003, 16'hFFFF, 0, 1, 16'hCAFE, 16'd6);
        vecs[10] = mk(1, 0, 16'h0002, 16'h0000, 1, 0, 16'h5678, 16'd7);
        vecs[11] = mk(1, 0, 16'h0004, 16'h0000, 1, 0, 16'hCAFE, 16'd8);
        vecs[12] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'hCAFE, 16'd8);
        vecs[13] = mk(1, 0, 16'h0202, 16'h0000, 1, 0, 16'h5678, 16'd9);

        rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 16'h0;
        rst4 = 1'b1; rd4 = 1'b0; wr4 = 1'b0; addr4 = 16'h0; din4 = 16'h0;
        #2;
        rst1 = 1'b0;
        rst4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst1_done",  {15'd0, done1},  16'd0);
        chk("rst1_stall", {15'd0, stall1}, 16'd0);
        chk("rst1_err",   {15'd0, err1},   16'd0);
        chk("rst1_dout",  dout1, 16'h0000);
        chk("rst1_cnt",   cnt1,  16'h0000);
        chk("rst4_done",  {15'd0, done4},  16'd0);
        chk("rst4_stall", {15'd0, stall4}, 16'd0);
        chk("rst4_dout",  dout4, 16'h0000);
        chk("rst4_cnt",   cnt4,  16'h0000);
        rst1 = 1'b1;
        rst4 = 1'b1;

        // LATENCY=1 table: first row lands on the very first edge after reset release
        for (int i = 0; i < 14; i++) begin
            rd1 = vecs[i].rd; wr1 = vecs[i].wr; addr1 = vecs[i].addr; din1 = vecs[i].din;
            tick();
            chk($sformatf("vec%0d_done", i),  {15'd0, done1},  {15'd0, vecs[i].done});
            chk($sformatf("vec%0d_stall", i), {15'd0, stall1}, 16'd0);
            chk($sformatf("vec%0d_err", i),   {15'd0, err1},   {15'd0, vecs[i].err});
            chk($sformatf("vec%0d_dout", i),  dout1, vecs[i].dout);
            chk($sformatf("vec%0d_cnt", i),   cnt1,  vecs[i].cnt);
        end
        rd1 = 1'b0; wr1 = 1'b0;
        tick();

        // LATENCY=4: write then held read of the same word
        wr4 = 1'b1; addr4 = 16'h0010; din4 = 16'hBEEF;
        tick();
        wr4 = 1'b0; rd4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) rd4 = 1'b0;
            chk($sformatf("raw_done_t%0d", k),  {15'd0, done4},  {15'd0, (k == 4 || k == 8)});
            chk($sformatf("raw_stall_t%0d", k), {15'd0, stall4}, {15'd0, !(k == 4 || k == 8)});
            if (k == 4) begin
                chk("raw_wr_dout", dout4, 16'h0000);
                chk("raw_wr_cnt",  cnt4,  16'd1);
            end
            if (k == 8) begin
                chk("raw_rd_dout", dout4, 16'hBEEF);
                chk("raw_rd_cnt",  cnt4,  16'd2);
            end
            tick();
        end

        // Inputs scrambled while waiting must not disturb the latched read
        rd4 = 1'b1; wr4 = 1'b0; addr4 = 16'h0010;
        tick();
        for (int k = 1; k <= 3; k++) begin
            rd4 = 1'($urandom_range(0, 1));
            wr4 = 1'($urandom_range(0, 1));
            addr4 = 16'($urandom);
            din4 = 16'($urandom);
            chk($sformatf("scr_stall_t%0d", k), {15'd0, stall4}, 16'd1);
            chk($sformatf("scr_err_t%0d", k),   {15'd0, err4},   16'd0);
            chk($sformatf("scr_done_t%0d", k),  {15'd0, done4},  16'd0);
            tick();
        end
        rd4 = 1'b0; wr4 = 1'b0;
        chk("scr_done", {15'd0, done4}, 16'd1);
        chk("scr_dout", dout4, 16'hBEEF);
        chk("scr_cnt",  cnt4,  16'd3);
        tick();
        chk("scr_after_err",  {15'd0, err4},  16'd0);
        chk("scr_after_done", {15'd0, done4}, 16'd0);

        // Reset in the middle of a write drops it
        wr4 = 1'b1; addr4 = 16'h0020; din4 = 16'h5555;
        tick();
        wr4 = 1'b0;
        repeat (3) tick();
        chk("pre_done", {15'd0, done4}, 16'd1);
        tick();
        wr4 = 1'b1; addr4 = 16'h0020; din4 = 16'hAAAA;
        tick();
        wr4 = 1'b0;
        chk("mid_stall1", {15'd0, stall4}, 16'd1);
        chk("mid_cnt",    cnt4, 16'd5);
        tick();
        chk("mid_stall2", {15'd0, stall4}, 16'd1);
        chk("mid_done2",  {15'd0, done4},  16'd0);
        rst4 = 1'b0;
        #1;
        chk("arst_stall", {15'd0, stall4}, 16'd0);
        chk("arst_done",  {15'd0, done4},  16'd0);
        chk("arst_err",   {15'd0, err4},   16'd0);
        chk("arst_dout",  dout4, 16'h0000);
        chk("arst_cnt",   cnt4,  16'h0000);
        tick();
        chk("inrst_done", {15'd0, done4}, 16'd0);
        rst4 = 1'b1; rd4 = 1'b1; addr4 = 16'h0020;
        tick();
        rd4 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("post_done_t%0d", k), {15'd0, done4}, 16'd0);
            tick();
        end
        chk("post_done", {15'd0, done4}, 16'd1);
        chk("post_dout", dout4, 16'h5555);
        chk("post_cnt",  cnt4,  16'd1);

        // Request counter saturation from a preloaded value
        force dut1.req_cnt_q = 16'hFFFC;
        #1;
        release dut1.req_cnt_q;
        #1;
        chk("sat_preload", cnt1, 16'hFFFC);
        rd1 = 1'b1; addr1 = 16'h0002;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("sat_cnt_%0d", k), cnt1, (k >= 3) ? 16'hFFFF : 16'(16'hFFFC + k));
            chk($sformatf("sat_done_%0d", k), {15'd0, done1}, 16'd1);
        end
        rd1 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
